dea_frame_loader: RTL and testbench
===================================

# dea_frame_loader

Upstream feeder for the DEA XOR cipher core. It accepts a byte stream over a valid/ready handshake and parses each frame: key bytes, a 0x0A terminator, message bytes, then a 0x0A terminator. It clears the DEA before each frame, loads the key with kset high, and streams the message with kset low. It also reports per-frame lengths, completion and framing errors to the top-level controller.

## Interface
- MAX_KEY, 5, maximum key bytes forwarded (DEA key store depth)
- MAX_MSG, 1024, maximum message bytes forwarded per frame
- TERM, 8'h0A, field terminator byte
- dclk  in  1  the single clock; all logic is rising-edge
- reset  in  1  synchronous, active-high
- s_valid  in  1  upstream byte valid
- s_data  in  8  upstream byte
- s_ready  out  1  block accepts s_data this cycle
- dea_reset  out  1  clear to the DEA key store
- dea_kset  out  1  1 = key byte, 0 = message byte
- dea_din  out  8  byte to the DEA
- dea_stb  out  1  one-cycle qualifier; the DEA advances on dclk only when high
- key_len  out  3  key bytes forwarded in the current frame
- msg_len  out  11  message bytes forwarded in the current frame
- frame_done  out  1  one-cycle pulse at frame end
- err  out  1  framing error in the current frame
- err_code  out  2  01 empty key, 10 key overflow, 11 message overflow

## Operation
- States: CLR, KEY, MSG, SKIPK, SKIPM, DONE.
- A byte is accepted when s_valid && s_ready.
- s_ready = 1 in KEY, MSG, SKIPK and SKIPM; 0 in CLR and DONE.
- CLR:
  - dea_reset = 1.
  - key_len, msg_len, err and err_code clear to 0.
  - Next state is KEY.
- KEY:
  - Accepted non-TERM byte with key_len < MAX_KEY: forward it with kset=1 and increment key_len.
  - Accepted non-TERM byte with key_len == MAX_KEY: set err with code 10, go to SKIPK. The byte is not forwarded.
  - TERM with key_len == 0: set err with code 01, go to SKIPM.
  - TERM otherwise: go to MSG.
- SKIPK:
  - Discard bytes.
  - TERM goes to SKIPM.
- MSG:
  - Accepted non-TERM byte with msg_len < MAX_MSG: forward it with kset=0 and increment msg_len.
  - Non-TERM byte at MAX_MSG: discard it, set err with code 11 (first error code wins), stay in MSG.
  - TERM goes to DONE.
- SKIPM:
  - Discard bytes.
  - TERM goes to DONE.
- DONE:
  - frame_done = 1.
  - Lengths and err stay stable for this cycle.
  - Next state is CLR.
- TERM bytes are never forwarded.
- An empty message (TERM immediately after the key terminator) is legal and gives msg_len = 0.
- err is sticky until the next CLR. err_code records the first error in the frame.
- Counters saturate; they never wrap.

## Timing
- While reset is high:
  - State is forced to CLR.
  - dea_reset = 1.
  - All other outputs are 0, including s_ready, dea_din and both lengths.
- First cycle after reset drops: state is CLR, dea_reset = 1, s_ready = 0.
- Next cycle: state is KEY, s_ready = 1.
- Forward latency is 1 cycle. A byte accepted at edge t drives dea_din, dea_kset and dea_stb = 1 in the cycle after t. These are registered.
- dea_stb = 0 on idle cycles and on discarded or TERM bytes. dea_din holds its last value.
- key_len and msg_len update at the same edge as dea_stb rises.
- Frame overhead:
  - Terminator of message accepted at edge t: DONE during cycle t+1, CLR during t+2.
  - s_ready high again at t+3. There are 2 non-ready cycles between frames.
- Back-pressure: upstream may hold s_valid high indefinitely. No byte is lost or duplicated across the DONE/CLR gap.
- s_valid low for any number of cycles in any state leaves state and counters unchanged.
- Reset mid-frame: the next cycle is CLR behaviour. No frame_done is issued for the abandoned frame.

## Test plan
- Reset, then stream "KEY\nHello\n" continuously:
  - dea_reset high through reset plus 1 cycle.
  - dea_stb pulses 3× with kset=1 (4B,45,59), then 5× with kset=0 (48,65,6C,6C,6F).
  - frame_done with key_len=3, msg_len=5, err=0.
- Key "ABCDEFG\nxy\n":
  - Only 41–45 forwarded; F, G, x, y are discarded.
  - frame_done with key_len=5, msg_len=0, err=1, err_code=10.
- "\nabc\n":
  - Nothing forwarded.
  - frame_done with err=1, err_code=01.
- Key "k\n" followed by 1030 message bytes and TERM:
  - 1024 forwarded; msg_len saturates at 1024.
  - err_code=11, frame_done asserted.
- Two back-to-back frames with s_valid held high and random s_valid gaps:
  - s_ready low exactly 2 cycles between frames.
  - dea_reset pulses once per frame.
  - Second frame's lengths are correct, with no byte lost.
- Reset asserted mid-message:
  - No frame_done.
  - Counters read 0.
  - The next frame parses correctly.

Source files
------------

// File: rtl/dea_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : dea_frame_loader
//  Description : Byte-stream frame parser feeding the DEA XOR cipher core.
//                Each frame is <key bytes> TERM <message bytes> TERM. The DEA
//                key store is cleared before every frame, key bytes are
//                forwarded with kset=1 and message bytes with kset=0.
//                Per-frame lengths, completion and framing errors are
//                reported to the top-level controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module dea_frame_loader #(
    parameter int         MAX_KEY = 5,
    parameter int         MAX_MSG = 1024,
    parameter logic [7:0] TERM    = 8'h0A
) (
    input  logic        dclk,
    input  logic        reset,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        dea_reset,
    output logic        dea_kset,
    output logic [7:0]  dea_din,
    output logic        dea_stb,
    output logic [2:0]  key_len,
    output logic [10:0] msg_len,
    output logic        frame_done,
    output logic        err,
    output logic [1:0]  err_code
);

    // Length limits sized to the reporting counters so comparisons are exact.
    localparam logic [2:0]  c_max_key = 3'(MAX_KEY);
    localparam logic [10:0] c_max_msg = 11'(MAX_MSG);

    // Error codes reported on err_code.
    localparam logic [1:0] c_err_none     = 2'b00;
    localparam logic [1:0] c_err_empty    = 2'b01;
    localparam logic [1:0] c_err_key_ovf  = 2'b10;
    localparam logic [1:0] c_err_msg_ovf  = 2'b11;

    typedef enum logic [2:0] {
        ST_CLR   = 3'd0,
        ST_KEY   = 3'd1,
        ST_MSG   = 3'd2,
        ST_SKIPK = 3'd3,
        ST_SKIPM = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_accept;
    logic       w_is_term;
    logic       w_fwd;
    logic       w_fwd_kset;
    logic       w_set_err;
    logic [1:0] w_new_code;
    logic       w_clear;

    // Only the field-parsing states take bytes; CLR and DONE form the
    // two-cycle gap between frames. Reset forces every control output idle.
    assign s_ready    = !reset && ((r_state == ST_KEY)   || (r_state == ST_MSG) ||
                                   (r_state == ST_SKIPK) || (r_state == ST_SKIPM));
    assign dea_reset  = reset || (r_state == ST_CLR);
    assign frame_done = !reset && (r_state == ST_DONE);

    assign w_accept  = s_valid && s_ready;
    assign w_is_term = (s_data == TERM);

    // Counters and error flags are cleared at the edge that leaves DONE so
    // they stay stable during DONE and read zero throughout CLR.
    assign w_clear = (r_state == ST_DONE) || (r_state == ST_CLR);

    // State register.
    always_ff @(posedge dclk) begin
        if (reset) begin
            r_state <= ST_CLR;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus forward/error qualifiers for the accepted byte.
    always_comb begin
        w_next     = r_state;
        w_fwd      = 1'b0;
        w_fwd_kset = 1'b0;
        w_set_err  = 1'b0;
        w_new_code = c_err_none;
        case (r_state)
            ST_CLR: begin
                w_next = ST_KEY;
            end
            ST_KEY: begin
                if (w_accept) begin
                    if (w_is_term) begin
                        if (key_len == 3'd0) begin
                            w_set_err  = 1'b1;
                            w_new_code = c_err_empty;
                            w_next     = ST_SKIPM;
                        end else begin
                            w_next = ST_MSG;
                        end
                    end else if (key_len < c_max_key) begin
                        w_fwd      = 1'b1;
                        w_fwd_kset = 1'b1;
                    end else begin
                        // Key store is full: the extra byte is dropped and the
                        // rest of the frame is skipped, message included.
                        w_set_err  = 1'b1;
                        w_new_code = c_err_key_ovf;
                        w_next     = ST_SKIPK;
                    end
                end
            end
            ST_SKIPK: begin
                if (w_accept && w_is_term) begin
                    w_next = ST_SKIPM;
                end
            end
            ST_MSG: begin
                if (w_accept) begin
                    if (w_is_term) begin
                        w_next = ST_DONE;
                    end else if (msg_len < c_max_msg) begin
                        w_fwd = 1'b1;
                    end else begin
                        // Over-long message: keep parsing to its terminator but
                        // stop forwarding.
                        w_set_err  = 1'b1;
                        w_new_code = c_err_msg_ovf;
                    end
                end
            end
            ST_SKIPM: begin
                if (w_accept && w_is_term) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_CLR;
            end
            default: begin
                w_next = ST_CLR;
            end
        endcase
    end

    // Registered byte path to the DEA; dea_din and dea_kset hold between strobes.
    always_ff @(posedge dclk) begin
        if (reset) begin
            dea_din  <= 8'h00;
            dea_kset <= 1'b0;
            dea_stb  <= 1'b0;
        end else begin
            dea_stb <= w_fwd;
            if (w_fwd) begin
                dea_din  <= s_data;
                dea_kset <= w_fwd_kset;
            end
        end
    end

    // Per-frame length counters; the forward qualifiers already stop them
    // at their limits, so they saturate instead of wrapping.
    always_ff @(posedge dclk) begin
        if (reset || w_clear) begin
            key_len <= 3'd0;
            msg_len <= 11'd0;
        end else if (w_fwd) begin
            if (w_fwd_kset) begin
                key_len <= key_len + 3'd1;
            end else begin
                msg_len <= msg_len + 11'd1;
            end
        end
    end

    // Sticky error flag; the first error of a frame fixes err_code.
    always_ff @(posedge dclk) begin
        if (reset || w_clear) begin
            err      <= 1'b0;
            err_code <= c_err_none;
        end else if (w_set_err && !err) begin
            err      <= 1'b1;
            err_code <= w_new_code;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dea_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dea_frame_loader
//  Description : Self-checking bench for dea_frame_loader. Frames are built as
//                key/message fields, a field-level reference model predicts
//                forwarded bytes and frame results, and a monitor compares
//                DUT output against the predicted queues.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dea_frame_loader;

    localparam logic [7:0] TERM = 8'h0A;

    typedef logic [7:0] bq_t[$];

    typedef struct packed {
        logic [2:0]  kl;
        logic [10:0] ml;
        logic        e;
        logic [1:0]  code;
    } frame_t;

    logic        dclk = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready;
    logic        dea_reset;
    logic        dea_kset;
    logic [7:0]  dea_din;
    logic        dea_stb;
    logic [2:0]  key_len;
    logic [10:0] msg_len;
    logic        frame_done;
    logic        err;
    logic [1:0]  err_code;

    dea_frame_loader dut (
        .dclk       (dclk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .dea_reset  (dea_reset),
        .dea_kset   (dea_kset),
        .dea_din    (dea_din),
        .dea_stb    (dea_stb),
        .key_len    (key_len),
        .msg_len    (msg_len),
        .frame_done (frame_done),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 dclk = ~dclk;

    logic [8:0] fwd_q[$];
    frame_t     frame_q[$];
    int         n_vec  = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic str2q(input string s, output bq_t q);
        q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == TERM) b = 8'h0B;
        return b;
    endfunction

    // Field-level reference: what the DEA should see for one frame and what
    // the frame report should be.
    task automatic model_frame(input bq_t key, input bq_t msg, input bit complete);
        frame_t f;
        int     n;
        f = '0;
        if (key.size() == 0) begin
            f.e    = 1'b1;
            f.code = 2'b01;
        end else if (key.size() > 5) begin
            for (int i = 0; i < 5; i++) fwd_q.push_back({1'b1, key[i]});
            f.kl   = 3'd5;
            f.e    = 1'b1;
            f.code = 2'b10;
        end else begin
            foreach (key[i]) fwd_q.push_back({1'b1, key[i]});
            f.kl = 3'(key.size());
            n = (msg.size() > 1024) ? 1024 : msg.size();
            for (int i = 0; i < n; i++) fwd_q.push_back({1'b0, msg[i]});
            f.ml = 11'(n);
            if (msg.size() > 1024) begin
                f.e    = 1'b1;
                f.code = 2'b11;
            end
        end
        if (complete) frame_q.push_back(f);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int g;
        if (gaps && $urandom_range(0, 2) == 0) begin
            s_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge dclk);
        end
        s_valid = 1'b1;
        s_data  = b;
        g = 0;
        while (!s_ready && g < 50) begin
            @(negedge dclk);
            g++;
        end
        if (!s_ready) fail_now("s_ready timeout");
        @(negedge dclk);
    endtask

    task automatic send_frame(input bq_t key, input bq_t msg, input bit gaps, input bit complete);
        model_frame(key, msg, complete);
        foreach (key[i]) send_byte(key[i], gaps);
        send_byte(TERM, gaps);
        foreach (msg[i]) send_byte(msg[i], gaps);
        if (complete) send_byte(TERM, gaps);
    endtask

    task automatic send_str(input string k, input string m, input bit gaps);
        bq_t kq, mq;
        str2q(k, kq);
        str2q(m, mq);
        send_frame(kq, mq, gaps, 1'b1);
    endtask

    task automatic send_random(input bit gaps);
        bq_t kq, mq;
        kq = {};
        mq = {};
        repeat ($urandom_range(0, 7)) kq.push_back(rand_byte());
        repeat ($urandom_range(0, 12)) mq.push_back(rand_byte());
        send_frame(kq, mq, gaps, 1'b1);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(negedge dclk);
    endtask

    // Monitor: compares forwarded bytes and frame reports against the
    // predicted queues, the 2-cycle ready gap and one DEA clear per frame.
    initial begin : monitor
        int     gap;
        int     clr_since;
        bit     gap_on;
        frame_t f;
        gap       = 0;
        clr_since = 0;
        gap_on    = 1'b0;
        forever begin
            @(posedge dclk);
            #1;
            if (reset) begin
                gap_on    = 1'b0;
                clr_since = 1;   // reset itself clears the DEA for the next frame
            end else begin
                if (dea_reset) clr_since++;
                if (dea_stb) begin
                    if (fwd_q.size() == 0) fail_now("unexpected dea_stb");
                    else check("forwarded {kset,din}", {23'd0, dea_kset, dea_din}, {23'd0, fwd_q.pop_front()});
                end
                if (frame_done) begin
                    if (frame_q.size() == 0) begin
                        fail_now("unexpected frame_done");
                    end else begin
                        f = frame_q.pop_front();
                        check("key_len", 32'(key_len), 32'(f.kl));
                        check("msg_len", 32'(msg_len), 32'(f.ml));
                        check("err", 32'(err), 32'(f.e));
                        check("err_code", 32'(err_code), 32'(f.code));
                    end
                    check("dea clears per frame", 32'(clr_since), 32'd1);
                    clr_since = 0;
                    gap_on    = 1'b1;
                    gap       = 1;
                end else if (gap_on) begin
                    if (!s_ready) gap++;
                    else begin
                        check("non-ready gap", 32'(gap), 32'd2);
                        gap_on = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bq_t kq, mq;

        // Reset behaviour
        reset = 1'b1;
        repeat (3) @(negedge dclk);
        check("rst dea_reset", 32'(dea_reset), 32'd1);
        check("rst s_ready", 32'(s_ready), 32'd0);
        check("rst dea_stb", 32'(dea_stb), 32'd0);
        check("rst dea_din", 32'(dea_din), 32'd0);
        check("rst dea_kset", 32'(dea_kset), 32'd0);
        check("rst key_len", 32'(key_len), 32'd0);
        check("rst msg_len", 32'(msg_len), 32'd0);
        check("rst frame_done", 32'(frame_done), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst err_code", 32'(err_code), 32'd0);
        reset = 1'b0;
        #1;
        check("post-rst s_ready", 32'(s_ready), 32'd0);
        check("post-rst dea_reset", 32'(dea_reset), 32'd1);
        @(negedge dclk);
        check("key s_ready", 32'(s_ready), 32'd1);
        check("key dea_reset", 32'(dea_reset), 32'd0);

        // Basic frame, continuous stream
        send_str("KEY", "Hello", 1'b0);
        idle(4);

        // Key overflow
        send_str("ABCDEFG", "xy", 1'b0);
        idle(4);

        // Empty key
        send_str("", "abc", 1'b0);
        idle(4);

        // Message overflow: 1030 bytes, only 1024 forwarded
        str2q("k", kq);
        mq = {};
        repeat (1030) mq.push_back(rand_byte());
        send_frame(kq, mq, 1'b0, 1'b1);
        idle(4);

        // Back-to-back frames with s_valid held high across the gap
        send_random(1'b0);
        send_random(1'b0);
        send_str("ab", "", 1'b0);
        idle(4);

        // Random frames with random s_valid gaps
        repeat (10) send_random(1'b1);
        idle(4);

        // Reset in the middle of a message
        str2q("ab", kq);
        str2q("xyz", mq);
        send_frame(kq, mq, 1'b0, 1'b0);
        idle(2);
        reset = 1'b1;
        @(negedge dclk);
        check("mid-rst key_len", 32'(key_len), 32'd0);
        check("mid-rst msg_len", 32'(msg_len), 32'd0);
        check("mid-rst err", 32'(err), 32'd0);
        check("mid-rst s_ready", 32'(s_ready), 32'd0);
        reset = 1'b0;
        send_str("pq", "rst", 1'b0);
        send_random(1'b1);
        idle(10);

        check("leftover forwarded bytes", 32'(fwd_q.size()), 32'd0);
        check("leftover frames", 32'(frame_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
